// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns one-clock trigger strobes into PULSE_LEN-clock pulses followed by a GAP_LEN holdoff, per channel.
// Define PULSE_STRETCHER_RETRIGGER_EN to let triggers during a pulse extend it instead of being dropped.
module pulse_stretcher #(
   parameter int   WIDTH       = 1,
   parameter int   PULSE_LEN   = 8,
   parameter int   GAP_LEN     = 0,
   parameter logic ACTIVE_HIGH = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] iv_trigger,
   input  logic             i_clr,
   output logic [WIDTH-1:0] ov_output,
   output logic [WIDTH-1:0] ov_busy,
   output logic [WIDTH-1:0] ov_overrun
);
   localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CW = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
   localparam logic RETRIG = 1'b1;
`else
   localparam logic RETRIG = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
   for (genvar c = 0; c < WIDTH; c++) begin : g_ch
      state_t st, st_nxt;
      logic [CW-1:0] cnt, cnt_nxt;
      logic term, accept, drop;
      logic out_q, busy_q, ovr_q;
      // The terminal edge of ACTIVE (no gap) or GAP is as good as IDLE for a new trigger
      always_comb begin
         term = cnt == '0;
         accept = iv_trigger[c] && (st == IDLE || (st == GAP && term) ||
                  (st == ACTIVE && (RETRIG || (term && GAP_LEN == 0))));
         drop = iv_trigger[c] && !accept;
         st_nxt = accept ? ACTIVE : !term ? st : (st == ACTIVE && GAP_LEN > 0) ? GAP : IDLE;
         cnt_nxt = accept ? PULSE_LOAD : (st == ACTIVE && term) ? GAP_LOAD : term ? '0 : cnt - CW'(1);
      end
      always_ff @(posedge i_clk or negedge i_rst_n)
         if (!i_rst_n) begin
            st <= IDLE;
            cnt <= '0;
            out_q <= ~ACTIVE_HIGH;
            busy_q <= 1'b0;
            ovr_q <= 1'b0;
         end else begin
            st <= st_nxt;
            cnt <= cnt_nxt;
            out_q <= (st_nxt == ACTIVE) ? ACTIVE_HIGH : ~ACTIVE_HIGH;
            busy_q <= st_nxt != IDLE;
            ovr_q <= drop | (ovr_q & ~i_clr);
         end
      assign ov_output[c] = out_q;
      assign ov_busy[c] = busy_q;
      assign ov_overrun[c] = ovr_q;
   end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: random triggers into two differently configured stretchers, checked against an end-time model.
module tb_pulse_stretcher;
   localparam int W = 2;
   localparam int PA = 4, GA = 2, PB = 3, GB = 0;
   logic i_clk = 1'b0, i_rst_n = 1'b0, i_clr = 1'b0;
   logic [W-1:0] iv_trigger = '0;
   logic [W-1:0] out_a, busy_a, ovr_a, out_b, busy_b, ovr_b;
   int n_chk = 0, n_pass = 0, cyc = 0;
   pulse_stretcher #(.WIDTH(W), .PULSE_LEN(PA), .GAP_LEN(GA), .ACTIVE_HIGH(1'b1)) dut_a (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_trigger(iv_trigger), .i_clr(i_clr),
      .ov_output(out_a), .ov_busy(busy_a), .ov_overrun(ovr_a));
   pulse_stretcher #(.WIDTH(W), .PULSE_LEN(PB), .GAP_LEN(GB), .ACTIVE_HIGH(1'b0)) dut_b (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_trigger(iv_trigger), .i_clr(i_clr),
      .ov_output(out_b), .ov_busy(busy_b), .ov_overrun(ovr_b));
   always #5 i_clk = ~i_clk;
   typedef struct {
      logic [W-1:0] oa, ba, ra, ob, bb, rb;
      int cyc;
   } exp_t;
   exp_t q[$];
`ifdef PULSE_STRETCHER_RETRIGGER_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif
   // Model: each channel remembers the edge at which its pulse and its holdoff end
   int act_end[2][W];
   int busy_end[2][W];
   logic [W-1:0] ovr_m[2];
   task automatic step();
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         int p, g;
         p = (d == 0) ? PA : PB;
         g = (d == 0) ? GA : GB;
         for (int c = 0; c < W; c++) begin
            bit drop;
            drop = 1'b0;
            if (!i_rst_n) begin
               act_end[d][c] = 0;
               busy_end[d][c] = 0;
               ovr_m[d][c] = 1'b0;
            end else begin
               if (iv_trigger[c]) begin
                  if (cyc >= busy_end[d][c] || (RETRIG && cyc <= act_end[d][c])) begin
                     act_end[d][c] = cyc + p;
                     busy_end[d][c] = cyc + p + g;
                  end else drop = 1'b1;
               end
               ovr_m[d][c] = drop ? 1'b1 : i_clr ? 1'b0 : ovr_m[d][c];
            end
         end
      end
      for (int c = 0; c < W; c++) begin
         e.oa[c] = cyc < act_end[0][c];
         e.ba[c] = cyc < busy_end[0][c];
         e.ob[c] = !(cyc < act_end[1][c]);
         e.bb[c] = cyc < busy_end[1][c];
      end
      e.ra = ovr_m[0];
      e.rb = ovr_m[1];
      e.cyc = cyc;
      q.push_back(e);
      cyc++;
   endtask
   always @(posedge i_clk) step();
   task automatic chk(input string name, input int c, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s edge=%0d got=%b expected=%b", name, c, got, exp);
   endtask
   initial begin
      forever begin
         @(negedge i_clk);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_a", e.cyc, out_a, e.oa);
            chk("busy_a", e.cyc, busy_a, e.ba);
            chk("ovr_a", e.cyc, ovr_a, e.ra);
            chk("out_b", e.cyc, out_b, e.ob);
            chk("busy_b", e.cyc, busy_b, e.bb);
            chk("ovr_b", e.cyc, ovr_b, e.rb);
         end
      end
   end
   task automatic rand_phase(input int n, input int inv_p, input bit hold);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         for (int c = 0; c < W; c++)
            iv_trigger[c] = hold ? (($urandom_range(0, 5) == 0) ? ~iv_trigger[c] : iv_trigger[c])
                                 : ($urandom_range(0, inv_p - 1) == 0);
         i_clr = $urandom_range(0, 15) == 0;
      end
   endtask
   initial begin
      repeat (3) @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      rand_phase(400, 12, 1'b0);
      rand_phase(400, 3, 1'b0);
      rand_phase(400, 1, 1'b1);
      rand_phase(400, 5, 1'b0);
      @(negedge i_clk);
      iv_trigger = '1;
      i_clr = 1'b1;
      @(negedge i_clk);
      iv_trigger = '0;
      i_clr = 1'b0;
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("async_out_a", cyc, out_a, '0);
      chk("async_busy_a", cyc, busy_a, '0);
      chk("async_ovr_a", cyc, ovr_a, '0);
      chk("async_out_b", cyc, out_b, '1);
      chk("async_busy_b", cyc, busy_b, '0);
      chk("async_ovr_b", cyc, ovr_b, '0);
      repeat (2) @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      repeat (6) @(negedge i_clk);
      rand_phase(300, 4, 1'b0);
      @(negedge i_clk);
      iv_trigger = '0;
      i_clr = 1'b0;
      repeat (12) @(negedge i_clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
